// File: rtl/fft_twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module      : fft_twiddle_gen
// Description : Streams radix-2 DIT twiddle factors (Q1.7, clamped to +/-127)
//               for every stage of an N-point FFT over a valid/ready handshake.
//               Optional macro FFT_TWIDDLE_IFFT_EN adds an 'inverse' input that
//               selects conjugate twiddles for the inverse transform.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_gen #(
    parameter int LOG2N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef FFT_TWIDDLE_IFFT_EN
    input  logic       inverse,
`endif
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] tw_re,
    output logic [7:0] tw_im,
    output logic [2:0] stage,
    output logic [2:0] bfly,
    output logic       last,
    output logic       done
);

    generate
        if (LOG2N < 2 || LOG2N > 4) begin : g_bad_log2n
            $error("fft_twiddle_gen: LOG2N must be in 2..4");
        end
    endgenerate

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [2:0] c_last_stage = 3'(LOG2N - 1);
    localparam logic [2:0] c_last_bfly  = 3'((1 << (LOG2N - 1)) - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last;
    logic       w_xfer;
    logic       w_load;
    logic [2:0] w_stage_nxt;
    logic [2:0] w_bfly_nxt;
    logic [2:0] w_mask;
    logic [2:0] w_addr;
    logic [7:0] w_rom_re;
    logic [7:0] w_rom_im;
    logic [7:0] w_im_out;
    logic [7:0] r_tw_re;
    logic [7:0] r_tw_im;
    logic [2:0] r_stage;
    logic [2:0] r_bfly;

    assign w_xfer = (r_state == c_st_run) && out_ready;
    assign w_load = (r_state == c_st_load) || (w_xfer && !r_last);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_load;
            c_st_load: w_state_nxt = c_st_run;
            c_st_run:  if (w_xfer && r_last) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (r_state == c_st_load) || (r_state == c_st_run);
        out_valid = (r_state == c_st_run);
        done      = (r_state == c_st_done);
    end

    // Counter position of the word about to be loaded
    always_comb begin
        w_stage_nxt = r_stage;
        w_bfly_nxt  = r_bfly + 3'd1;
        if (r_state == c_st_load) begin
            w_stage_nxt = 3'd0;
            w_bfly_nxt  = 3'd0;
        end else if (r_bfly == c_last_bfly) begin
            w_stage_nxt = r_stage + 3'd1;
            w_bfly_nxt  = 3'd0;
        end
    end

    // ROM address = (bfly mod 2^stage) << (3 - stage); independent of LOG2N
    always_comb begin
        case (w_stage_nxt)
            3'd0:    w_mask = 3'b000;
            3'd1:    w_mask = 3'b001;
            3'd2:    w_mask = 3'b011;
            default: w_mask = 3'b111;
        endcase
        w_addr = (w_bfly_nxt & w_mask) << (3'd3 - w_stage_nxt);
    end

    always_comb begin
        case (w_addr)
            3'd0:    begin w_rom_re = 8'h7F; w_rom_im = 8'h00; end
            3'd1:    begin w_rom_re = 8'h76; w_rom_im = 8'hCF; end
            3'd2:    begin w_rom_re = 8'h5B; w_rom_im = 8'hA5; end
            3'd3:    begin w_rom_re = 8'h31; w_rom_im = 8'h8A; end
            3'd4:    begin w_rom_re = 8'h00; w_rom_im = 8'h81; end
            3'd5:    begin w_rom_re = 8'hCF; w_rom_im = 8'h8A; end
            3'd6:    begin w_rom_re = 8'hA5; w_rom_im = 8'hA5; end
            default: begin w_rom_re = 8'h8A; w_rom_im = 8'hCF; end
        endcase
    end

`ifdef FFT_TWIDDLE_IFFT_EN
    logic r_inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv <= 1'b0;
        end else if (r_state == c_st_idle && start) begin
            r_inv <= inverse;
        end
    end

    assign w_im_out = r_inv ? (8'd0 - w_rom_im) : w_rom_im;
`else
    assign w_im_out = w_rom_im;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tw_re <= 8'd0;
            r_tw_im <= 8'd0;
            r_stage <= 3'd0;
            r_bfly  <= 3'd0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_tw_re <= w_rom_re;
            r_tw_im <= w_im_out;
            r_stage <= w_stage_nxt;
            r_bfly  <= w_bfly_nxt;
            r_last  <= (w_stage_nxt == c_last_stage) && (w_bfly_nxt == c_last_bfly);
        end
    end

    assign tw_re = r_tw_re;
    assign tw_im = r_tw_im;
    assign stage = r_stage;
    assign bfly  = r_bfly;
    assign last  = r_last;

endmodule
`default_nettype wire
